fpga_reg_bist: RTL and testbench

FPGA_REG_BIST -- requirements
Module: fpga_reg_bist

---
 rtl/fpga_reg_bist.sv | 119 +++++++++++
 tb/tb_fpga_reg_bist.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reg_bist.sv
// Built-in self test for a single enabled flip-flop: drives {e_o,d_o}, models the ideal response and scores q_i.
// Define FPGA_REG_BIST_LFSR_EN to source vectors from an 8-bit LFSR instead of the 00,01,10,11 counter pattern.
module fpga_reg_bist #(
  parameter int         N_VEC = 8,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       q_i,
  output logic       e_o,
  output logic       d_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] c_tot_o,
  output logic [4:0] c_ok_o,
  output logic [4:0] c_fail_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [4:0] LAST = 5'(N_VEC - 1);

  state_t     state, state_nxt;
  logic [4:0] vec_idx;
  logic       drv_vld, chk_vld, exp_q;
  logic       start_run, last_vec;
  logic [1:0] vec0, vec_nxt;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'd31) ? c : c + 5'd1;
  endfunction

`ifdef FPGA_REG_BIST_LFSR_EN
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [7:0] lfsr, lfsr_adv;

  assign lfsr_adv = lfsr_next(lfsr);
  assign vec0     = SEED[1:0];
  assign vec_nxt  = lfsr_adv[1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                     lfsr <= SEED;
    else if (start_run)                lfsr <= SEED;
    else if (state == RUN && !last_vec) lfsr <= lfsr_adv;
  end
`else
  assign vec0    = 2'b00;
  assign vec_nxt = vec_idx[1:0] + 2'd1;
`endif

  assign last_vec  = (vec_idx == LAST);
  assign start_run = start_i && (state == IDLE || state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    if (start_i) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Drive stage: one vector per RUN cycle; d_o holds once RUN ends.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      vec_idx <= 5'd0;
      e_o     <= 1'b0;
      d_o     <= 1'b0;
      drv_vld <= 1'b0;
      chk_vld <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      chk_vld <= drv_vld;
      exp_q   <= e_o ? d_o : exp_q;
      if (start_run) begin
        vec_idx    <= 5'd0;
        {e_o, d_o} <= vec0;
        drv_vld    <= 1'b1;
      end else if (state == RUN && !last_vec) begin
        vec_idx    <= vec_idx + 5'd1;
        {e_o, d_o} <= vec_nxt;
      end else begin
        e_o     <= 1'b0;
        drv_vld <= 1'b0;
      end
    end
  end

  // Check stage: scores the vector captured by the register-under-test one edge earlier.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      c_tot_o  <= 5'd0;
      c_ok_o   <= 5'd0;
      c_fail_o <= 5'd0;
    end else if (start_run) begin
      c_tot_o  <= 5'd0;
      c_ok_o   <= 5'd0;
      c_fail_o <= 5'd0;
    end else if (chk_vld) begin
      c_tot_o <= sat_inc(c_tot_o);
      if (q_i == exp_q) c_ok_o   <= sat_inc(c_ok_o);
      else              c_fail_o <= sat_inc(c_fail_o);
    end
  end

  assign busy_o = (state == RUN) || (state == FLUSH);
  assign done_o = (state == DONE);
  assign pass_o = done_o && (c_fail_o == 5'd0);

endmodule

// File: tb/tb_fpga_reg_bist.sv
// Directed bench for fpga_reg_bist: a good register on dut_a, selectable faulty registers on dut_b.
module tb_fpga_reg_bist;

`ifdef FPGA_REG_BIST_LFSR_EN
  localparam int NA = 31;
`else
  localparam int NA = 8;
`endif
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b;
  logic       e_a, d_a, busy_a, done_a, pass_a, q_a;
  logic       e_b, d_b, busy_b, done_b, pass_b, q_b;
  logic [4:0] tot_a, ok_a, fail_a, tot_b, ok_b, fail_b;
  int         mode_b;
  int         n_chk = 0;
  int         n_fail = 0;

  fpga_reg_bist #(.N_VEC(NA), .SEED(SEED)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .q_i(q_a),
    .e_o(e_a), .d_o(d_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .c_tot_o(tot_a), .c_ok_o(ok_a), .c_fail_o(fail_a)
  );

  fpga_reg_bist #(.N_VEC(4), .SEED(SEED)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_b), .q_i(q_b),
    .e_o(e_b), .d_o(d_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .c_tot_o(tot_b), .c_ok_o(ok_b), .c_fail_o(fail_b)
  );

  // Registers under test: dut_a sees an ideal enabled DFF; dut_b: 0 good, 1 stuck-at-0, 2 ignores E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q_a <= 1'b0;
    else if (e_a) q_a <= d_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_b <= 1'b0;
    else begin
      case (mode_b)
        1:       q_b <= 1'b0;
        2:       q_b <= d_b;
        default: if (e_b) q_b <= d_b;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n;
    n = 0;
    while (((which == 0) ? done_a : done_b) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", (which == 0) ? done_a : done_b, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] l;
    logic [1:0] ev;
    int         busy_cnt, n;

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_b  = 0;
    ev      = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_e",    e_a, 0);
    check("rst_d",    d_a, 0);
    check("rst_tot",  tot_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_autostart", busy_a, 0);

    // Full run with a good register: vector sequence and exact latency to DONE.
    l = SEED;
    pulse_start(0);
    for (int i = 0; i < NA; i++) begin
`ifdef FPGA_REG_BIST_LFSR_EN
      ev = l[1:0];
      l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
`else
      ev = i[1:0];
`endif
      check("run_vec",  {e_a, d_a}, ev);
      check("run_busy", busy_a, 1);
      @(negedge clk);
    end
    check("flush_busy", busy_a, 1);
    check("flush_done", done_a, 0);
    check("flush_e",    e_a, 0);
    check("flush_d",    d_a, ev[0]);
    @(negedge clk);
    check("done_flag", done_a, 1);
    check("done_busy", busy_a, 0);
    check("done_tot",  tot_a, NA);
    check("done_ok",   ok_a, NA);
    check("done_fail", fail_a, 0);
    check("done_pass", pass_a, 1);
    repeat (2) @(negedge clk);
    check("hold_tot",  tot_a, NA);
    check("hold_pass", pass_a, 1);

    // Restart from DONE, with a start pulse in the third RUN cycle that must be ignored.
    pulse_start(0);
    check("restart_clear_tot", tot_a, 0);
    busy_cnt = 0;
    n = 0;
    while (!done_a && n < 100) begin
      if (busy_a) busy_cnt++;
      start_a = (n == 2);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    check("ignore_busy_cycles", busy_cnt, NA + 1);
    check("ignore_done", done_a, 1);
    check("ignore_tot",  tot_a, NA);
    check("ignore_ok",   ok_a, NA);
    check("ignore_pass", pass_a, 1);

    // Asynchronous reset mid-run, then a clean run.
    pulse_start(0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_pass", pass_a, 0);
    check("abort_e",    e_a, 0);
    check("abort_d",    d_a, 0);
    check("abort_tot",  tot_a, 0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", busy_a, 0);
    check("abort_no_done",    done_a, 0);
    pulse_start(0);
    wait_done(0);
    check("clean_tot",  tot_a, NA);
    check("clean_ok",   ok_a, NA);
    check("clean_fail", fail_a, 0);
    check("clean_pass", pass_a, 1);

`ifndef FPGA_REG_BIST_LFSR_EN
    // Stuck-at-0: expected 0,0,0,1 so only the last vector fails.
    do_reset();
    mode_b = 1;
    pulse_start(1);
    wait_done(1);
    check("stuck_tot",  tot_b, 4);
    check("stuck_ok",   ok_b, 3);
    check("stuck_fail", fail_b, 1);
    check("stuck_pass", pass_b, 0);

    // Rerun without reset: exp_q starts at 1, so vectors 0,1,3 fail.
    pulse_start(1);
    check("rerun_clear_tot", tot_b, 0);
    wait_done(1);
    check("rerun_tot",  tot_b, 4);
    check("rerun_ok",   ok_b, 1);
    check("rerun_fail", fail_b, 3);

    // Plain DFF ignoring E: q = 0,1,0,1, fails on vector 01.
    do_reset();
    mode_b = 2;
    pulse_start(1);
    repeat (3) @(negedge clk);
    check("noen_mid_tot",  tot_b, 2);
    check("noen_mid_fail", fail_b, 1);
    wait_done(1);
    check("noen_tot",  tot_b, 4);
    check("noen_ok",   ok_b, 3);
    check("noen_fail", fail_b, 1);
    check("noen_pass", pass_b, 0);

    do_reset();
    mode_b = 0;
    pulse_start(1);
    wait_done(1);
    check("good4_ok",   ok_b, 4);
    check("good4_pass", pass_b, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
